dma_engine: RTL and testbench

- Parametrised multi-channel DMA controller on the SoC bus.
- Exposes an MMIO register file of NCHAN channels, each with src, dest, size and ctl registers.
- Runs memory-to-memory word copies through one bus-master port.
- Channels are granted round-robin; a granted channel runs to completion before re-arbitration.

---
 rtl/dma_pkg.sv | 37 +++
 rtl/dma_rr_arb.sv | 36 +++
 rtl/dma_engine.sv | 263 ++++++++++++++++++++++++++
 tb/tb_dma_engine.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the dma_engine register file, FSM and arbiter.
// Optional macro DMA_IRQ_EN enables the DONE & IE interrupt output.
package dma_pkg;

   localparam int unsigned SRC_OFF  = 0;
   localparam int unsigned DEST_OFF = 8;
   localparam int unsigned SIZE_OFF = 16;
   localparam int unsigned CTL_OFF  = 24;

   localparam int unsigned CTL_START = 0;
   localparam int unsigned CTL_DONE  = 1;
   localparam int unsigned CTL_BUSY  = 2;
   localparam int unsigned CTL_IE    = 3;

   localparam int unsigned SIZE_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      RD,
      WR,
      FINISH
   } dma_state_t;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_SRC,
      SEL_DEST,
      SEL_SIZE,
      SEL_CTL
   } reg_sel_t;

   function automatic int unsigned idx_width(int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dma_rr_arb.sv
// Combinational round-robin picker: lowest requesting index at or after ptr_i,
// wrapping modulo NCHAN.
module dma_rr_arb
   import dma_pkg::*;
#(
   parameter int unsigned NCHAN = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [NCHAN-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [NCHAN-1:0] gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   int unsigned c;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      c       = 0;
      for (int unsigned i = 0; i < NCHAN; i++) begin
         c = 32'(ptr_i) + i;
         if (c >= NCHAN) begin
            c = c - NCHAN;
         end
         if (!valid_o && req_i[c[IDX_W-1:0]]) begin
            valid_o                = 1'b1;
            gnt_o[c[IDX_W-1:0]]    = 1'b1;
            idx_o                  = c[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/dma_engine.sv
// Multi-channel memory-to-memory DMA with MMIO channel registers and one bus master.
// Define DMA_IRQ_EN to drive irq from OR(DONE & IE); otherwise irq is tied low.
module dma_engine
   import dma_pkg::*;
#(
   parameter int unsigned NCHAN       = 4,
   parameter logic [47:0] MMIO_BASE   = 48'h1000140,
   parameter int unsigned CHAN_STRIDE = 32,
   parameter int unsigned ADDR_W      = 48,
   parameter int unsigned DATA_W      = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [47:0]       mmio_addr,
   input  logic [DATA_W-1:0] mmio_wdata,
   output logic [DATA_W-1:0] mmio_rdata,
   input  logic              mmio_re,
   input  logic              mmio_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_req,
   output logic              mem_we,
   input  logic              mem_ack,
   output logic              irq
);

   localparam int unsigned       IDX_W = idx_width(NCHAN);
   localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(DATA_W / 8);

   logic [ADDR_W-1:0] src_q  [NCHAN];
   logic [ADDR_W-1:0] src_d  [NCHAN];
   logic [ADDR_W-1:0] dst_q  [NCHAN];
   logic [ADDR_W-1:0] dst_d  [NCHAN];
   logic [SIZE_W-1:0] size_q [NCHAN];
   logic [SIZE_W-1:0] size_d [NCHAN];
   logic [NCHAN-1:0]  start_q, start_d;
   logic [NCHAN-1:0]  done_q,  done_d;
   logic [NCHAN-1:0]  busy_q,  busy_d;
   logic [NCHAN-1:0]  ie_q,    ie_d;

   dma_state_t        state_q;
   logic [IDX_W-1:0]  gnt_q;
   logic [IDX_W-1:0]  ptr_q;
   logic [ADDR_W-1:0] cur_src_q;
   logic [ADDR_W-1:0] cur_dst_q;
   logic [SIZE_W-1:0] rem_q;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] rdata_q;

   reg_sel_t          sel;
   logic [IDX_W-1:0]  sel_ch;
   logic [DATA_W-1:0] rd_val;
   logic [NCHAN-1:0]  arb_gnt;
   logic [IDX_W-1:0]  arb_idx;
   logic              arb_valid;
   logic              wr_c;
   logic              locked;

   function automatic logic [47:0] reg_addr(int unsigned ch, int unsigned off);
      return MMIO_BASE + 48'(ch * CHAN_STRIDE) + 48'(off);
   endfunction

   dma_rr_arb #(
      .NCHAN (NCHAN),
      .IDX_W (IDX_W)
   ) u_arb (
      .req_i   (start_q),
      .ptr_i   (ptr_q),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   // Exact-match decode: misaligned or out-of-window addresses select nothing.
   always_comb begin
      sel    = SEL_NONE;
      sel_ch = '0;
      for (int unsigned c = 0; c < NCHAN; c++) begin
         if (mmio_addr == reg_addr(c, SRC_OFF)) begin
            sel    = SEL_SRC;
            sel_ch = IDX_W'(c);
         end else if (mmio_addr == reg_addr(c, DEST_OFF)) begin
            sel    = SEL_DEST;
            sel_ch = IDX_W'(c);
         end else if (mmio_addr == reg_addr(c, SIZE_OFF)) begin
            sel    = SEL_SIZE;
            sel_ch = IDX_W'(c);
         end else if (mmio_addr == reg_addr(c, CTL_OFF)) begin
            sel    = SEL_CTL;
            sel_ch = IDX_W'(c);
         end
      end
   end

   always_comb begin
      rd_val = '0;
      case (sel)
         SEL_SRC:  rd_val = DATA_W'(src_q[sel_ch]);
         SEL_DEST: rd_val = DATA_W'(dst_q[sel_ch]);
         SEL_SIZE: rd_val = DATA_W'(size_q[sel_ch]);
         SEL_CTL:  rd_val = DATA_W'({ie_q[sel_ch], busy_q[sel_ch],
                                     done_q[sel_ch], start_q[sel_ch]});
         default:  rd_val = '0;
      endcase
   end

   // FSM completion overrides MMIO on START/DONE, except a START written
   // in the FINISH cycle survives so the channel re-arbitrates.
   always_comb begin
      src_d   = src_q;
      dst_d   = dst_q;
      size_d  = size_q;
      start_d = start_q;
      done_d  = done_q;
      busy_d  = busy_q;
      ie_d    = ie_q;
      wr_c    = 1'b0;
      locked  = 1'b0;
      for (int unsigned c = 0; c < NCHAN; c++) begin
         wr_c   = mmio_we && (sel_ch == IDX_W'(c));
         locked = start_q[c] | busy_q[c];
         if (wr_c && !locked) begin
            case (sel)
               SEL_SRC:  src_d[c]  = mmio_wdata[ADDR_W-1:0];
               SEL_DEST: dst_d[c]  = mmio_wdata[ADDR_W-1:0];
               SEL_SIZE: size_d[c] = mmio_wdata[SIZE_W-1:0];
               default:  ;
            endcase
         end
         if (wr_c && (sel == SEL_CTL)) begin
            start_d[c] = start_q[c] | mmio_wdata[CTL_START];
            done_d[c]  = done_q[c] & ~mmio_wdata[CTL_DONE];
            ie_d[c]    = mmio_wdata[CTL_IE];
         end
         if ((state_q == FINISH) && (gnt_q == IDX_W'(c))) begin
            start_d[c] = wr_c && (sel == SEL_CTL) && mmio_wdata[CTL_START];
            busy_d[c]  = 1'b0;
            done_d[c]  = 1'b1;
         end
         if ((state_q == IDLE) && arb_gnt[c]) begin
            busy_d[c] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned c = 0; c < NCHAN; c++) begin
            src_q[c]  <= '0;
            dst_q[c]  <= '0;
            size_q[c] <= '0;
         end
         start_q <= '0;
         done_q  <= '0;
         busy_q  <= '0;
         ie_q    <= '0;
      end else begin
         src_q   <= src_d;
         dst_q   <= dst_d;
         size_q  <= size_d;
         start_q <= start_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         ie_q    <= ie_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (mmio_re) begin
         rdata_q <= rd_val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         ptr_q       <= '0;
         cur_src_q   <= '0;
         cur_dst_q   <= '0;
         rem_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arb_valid) begin
                  gnt_q     <= arb_idx;
                  cur_src_q <= src_q[arb_idx];
                  cur_dst_q <= dst_q[arb_idx];
                  rem_q     <= size_q[arb_idx];
                  state_q   <= CHECK;
               end
            end
            CHECK: begin
               if (rem_q == '0) begin
                  state_q <= FINISH;
               end else begin
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= cur_src_q;
                  state_q    <= RD;
               end
            end
            RD: begin
               // mem_wdata_q doubles as the read-to-write buffer.
               if (mem_ack) begin
                  mem_wdata_q <= mem_rdata;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= cur_dst_q;
                  state_q     <= WR;
               end
            end
            WR: begin
               if (mem_ack) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  cur_src_q <= cur_src_q + STEP;
                  cur_dst_q <= cur_dst_q + STEP;
                  rem_q     <= rem_q - 1'b1;
                  state_q   <= CHECK;
               end
            end
            FINISH: begin
               ptr_q   <= (gnt_q == IDX_W'(NCHAN - 1)) ? '0 : gnt_q + 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mmio_rdata = rdata_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

`ifdef DMA_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |(done_d & ie_d);
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_dma_engine.sv
// Randomized scoreboard bench for dma_engine: expected bus beats are queued from a
// transfer-level model and popped by a monitor on every acknowledged beat.
`timescale 1ns/1ps
module tb_dma_engine;

   localparam int unsigned NCHAN  = 4;
   localparam logic [47:0] BASE   = 48'h1000140;
   localparam int unsigned STRIDE = 32;
`ifdef DMA_IRQ_EN
   localparam bit IRQ_ON = 1'b1;
`else
   localparam bit IRQ_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [47:0] mmio_addr = '0;
   logic [63:0] mmio_wdata = '0;
   logic [63:0] mmio_rdata;
   logic        mmio_re = 1'b0;
   logic        mmio_we = 1'b0;
   logic [47:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata = '0;
   logic        mem_req;
   logic        mem_we;
   logic        mem_ack = 1'b0;
   logic        irq;

   dma_engine #(
      .NCHAN       (NCHAN),
      .MMIO_BASE   (BASE),
      .CHAN_STRIDE (STRIDE),
      .ADDR_W      (48),
      .DATA_W      (64)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mmio_addr  (mmio_addr),
      .mmio_wdata (mmio_wdata),
      .mmio_rdata (mmio_rdata),
      .mmio_re    (mmio_re),
      .mmio_we    (mmio_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_ack    (mem_ack),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          we;
      logic [47:0] addr;
      logic [63:0] data;
   } beat_t;

   beat_t       exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          mptr = 0;
   bit          hold_wr = 1'b0;
   int          late_req = 0;
   logic [47:0] csrc [NCHAN];
   logic [47:0] cdst [NCHAN];
   int          csize [NCHAN];
   bit          cie [NCHAN];

   function automatic logic [63:0] mem_word(logic [47:0] a);
      return {a[31:0] ^ 32'hC0DE_7A11, 16'h5A5A, a[47:32]};
   endfunction

   function automatic logic [47:0] ra(int ch, int off);
      return BASE + 48'(ch * STRIDE + off);
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Slave: acks each request after 1..3 cycles, returning mem_word(addr) on reads.
   initial begin
      int cnt = 0;
      int lat = 2;
      int late_done = 0;
      forever begin
         @(posedge clk);
         #1;
         mem_ack   = 1'b0;
         mem_rdata = {$urandom, $urandom};
         if (!rst_n) begin
            cnt = 0;
         end else if (late_req != late_done) begin
            late_done = late_req;
            mem_ack   = 1'b1;
         end else if (mem_req && !(hold_wr && mem_we)) begin
            cnt++;
            if (cnt >= lat) begin
               mem_ack = 1'b1;
               if (!mem_we) mem_rdata = mem_word(mem_addr);
               cnt = 0;
               lat = $urandom_range(1, 3);
            end
         end else begin
            cnt = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && mem_req && mem_ack) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL beat_unexpected: got we=%0d addr=0x%0h expected no beat", mem_we, mem_addr);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            checks++;
            if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.data)) begin
               failures++;
               $display("FAIL beat: got we=%0d addr=0x%0h data=0x%0h expected we=%0d addr=0x%0h data=0x%0h",
                        mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic mmio_wr(logic [47:0] a, logic [63:0] d);
      mmio_addr  = a;
      mmio_wdata = d;
      mmio_we    = 1'b1;
      @(negedge clk);
      mmio_we    = 1'b0;
   endtask

   task automatic mmio_rd(logic [47:0] a, output logic [63:0] d);
      mmio_addr = a;
      mmio_re   = 1'b1;
      @(negedge clk);
      mmio_re   = 1'b0;
      d         = mmio_rdata;
   endtask

   task automatic rd_chk(string name, logic [47:0] a, logic [63:0] exp);
      logic [63:0] d;
      mmio_rd(a, d);
      check(name, d, exp);
   endtask

   task automatic wait_done(int ch, int budget);
      logic [63:0] d;
      int n = 0;
      do begin
         mmio_rd(ra(ch, 24), d);
         n++;
      end while (d[1] == 1'b0 && n < budget);
      if (d[1] == 1'b0) begin
         checks++;
         failures++;
         $display("FAIL wait_done ch%0d: got ctl=0x%0h expected DONE within %0d polls", ch, d, budget);
      end
   endtask

   task automatic push_xfer(logic [47:0] src, logic [47:0] dst, int size);
      for (int i = 0; i < size; i++) begin
         logic [47:0] s;
         logic [47:0] d;
         s = src + 48'(8 * i);
         d = dst + 48'(8 * i);
         exp_q.push_back('{1'b0, s, 64'h0});
         exp_q.push_back('{1'b1, d, mem_word(s)});
      end
   endtask

   task automatic config_ch(int ch);
      mmio_wr(ra(ch, 0), 64'(csrc[ch]));
      mmio_wr(ra(ch, 8), 64'(cdst[ch]));
      mmio_wr(ra(ch, 16), 64'(csize[ch]));
   endtask

   // blk runs first on an idle engine; channels in pmask go pending while it runs.
   task automatic round(int blk, logic [NCHAN-1:0] pmask);
      bit left [NCHAN];
      int order[$];
      int p;
      int np = 0;
      bit any_ie = 1'b0;
      for (int c = 0; c < NCHAN; c++) begin
         left[c]  = (c != blk) && pmask[c];
         csrc[c]  = ($urandom_range(0, 5) == 0) ? 48'hFFFF_FFFF_FFF0
                                                : 48'({$urandom_range(0, 4095), 3'b000});
         cdst[c]  = 48'h10_0000 + 48'({$urandom_range(0, 4095), 3'b000});
         csize[c] = (c == blk) ? 4 : $urandom_range(0, 3);
         cie[c]   = 1'($urandom_range(0, 1));
         if (left[c]) np++;
      end
      order.push_back(blk);
      p = (blk + 1) % NCHAN;
      repeat (np) begin
         for (int k = 0; k < NCHAN; k++) begin
            int c;
            c = (p + k) % NCHAN;
            if (left[c]) begin
               order.push_back(c);
               left[c] = 1'b0;
               p = (c + 1) % NCHAN;
               break;
            end
         end
      end
      foreach (order[i]) begin
         config_ch(order[i]);
         push_xfer(csrc[order[i]], cdst[order[i]], csize[order[i]]);
         any_ie |= cie[order[i]];
      end
      foreach (order[i]) mmio_wr(ra(order[i], 24), {60'h0, cie[order[i]], 3'b001});
      mptr = p;
      wait_done(order[order.size() - 1], 400);
      foreach (order[i]) rd_chk("rr_ctl_done", ra(order[i], 24), {60'h0, cie[order[i]], 3'b010});
      check("rr_irq", 64'(irq), 64'(IRQ_ON & any_ie));
      foreach (order[i]) mmio_wr(ra(order[i], 24), 64'h2);
      check("rr_irq_clear", 64'(irq), 64'h0);
      check("rr_drained", 64'(exp_q.size()), 64'h0);
   endtask

   initial begin
      logic [63:0] d;
      bit saw;
      int n;

      repeat (2) @(negedge clk);
      check("reset_mem_req", 64'(mem_req), 64'h0);
      check("reset_irq", 64'(irq), 64'h0);
      check("reset_rdata", mmio_rdata, 64'h0);
      rst_n = 1'b1;
      @(negedge clk);
      rd_chk("reset_ctl0", ra(0, 24), 64'h0);

      mmio_wr(ra(0, 0), 64'hFFFF_1234_5678_9AB8);
      rd_chk("src_trunc", ra(0, 0), 64'h0000_1234_5678_9AB8);
      mmio_addr = ra(0, 8);
      repeat (2) @(negedge clk);
      check("rdata_hold", mmio_rdata, 64'h0000_1234_5678_9AB8);
      rd_chk("unmapped_end", ra(NCHAN, 0), 64'h0);
      mmio_wr(ra(3, 16), 64'hFFFF_1234);
      rd_chk("size_trunc", ra(3, 16), 64'h1234);
      rd_chk("misaligned", BASE + 48'd4, 64'h0);

      csrc[0] = 48'h2000; cdst[0] = 48'h3000; csize[0] = 3;
      config_ch(0);
      push_xfer(48'h2000, 48'h3000, 3);
      mmio_wr(ra(0, 24), 64'h9);
      mptr = 1;
      wait_done(0, 200);
      rd_chk("ch0_ctl", ra(0, 24), 64'hA);
      check("ch0_irq", 64'(irq), 64'(IRQ_ON));
      mmio_wr(ra(0, 24), 64'h2);
      rd_chk("ch0_ctl_clr", ra(0, 24), 64'h0);
      check("ch0_irq_clr", 64'(irq), 64'h0);
      check("ch0_drained", 64'(exp_q.size()), 64'h0);

      mmio_wr(ra(1, 16), 64'h0);
      mmio_wr(ra(1, 24), 64'h1);
      rd_chk("size0_e1", ra(1, 24), 64'h1);
      rd_chk("size0_e2", ra(1, 24), 64'h5);
      rd_chk("size0_e3", ra(1, 24), 64'h5);
      rd_chk("size0_e4", ra(1, 24), 64'h2);
      mmio_wr(ra(1, 24), 64'h2);
      mptr = 2;

      csrc[2] = 48'h4000; cdst[2] = 48'h5000; csize[2] = 3;
      config_ch(2);
      push_xfer(48'h4000, 48'h5000, 3);
      mmio_wr(ra(2, 24), 64'h1);
      n = 0;
      while (!mem_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("mid_req_seen", 64'(mem_req), 64'h1);
      mmio_wr(ra(2, 0), 64'hDEAD);
      rd_chk("mid_src_kept", ra(2, 0), 64'h4000);
      wait_done(2, 200);
      rd_chk("mid_ctl", ra(2, 24), 64'h2);
      mmio_wr(ra(2, 24), 64'h2);
      check("mid_drained", 64'(exp_q.size()), 64'h0);
      mptr = 3;

      round(0, 4'b1010);
      round(2, 4'b1010);
      repeat (6) round($urandom_range(0, NCHAN - 1), 4'($urandom_range(0, 15)));

      csrc[0] = 48'h100; cdst[0] = 48'h200; csize[0] = 2;
      config_ch(0);
      exp_q.push_back('{1'b0, 48'h100, 64'h0});
      hold_wr = 1'b1;
      mmio_wr(ra(0, 24), 64'h9);
      n = 0;
      while (!(mem_req && mem_we) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rst_in_wr", 64'(mem_req && mem_we), 64'h1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_req_drop", 64'(mem_req), 64'h0);
      check("rst_addr", 64'(mem_addr), 64'h0);
      check("rst_rdata", mmio_rdata, 64'h0);
      check("rst_irq", 64'(irq), 64'h0);
      exp_q.delete();
      mptr = 0;
      repeat (2) @(negedge clk);
      rst_n   = 1'b1;
      hold_wr = 1'b0;
      late_req++;
      saw = 1'b0;
      repeat (4) begin
         @(negedge clk);
         saw |= mem_req;
      end
      check("late_ack_ignored", 64'(saw), 64'h0);
      rd_chk("rst_ctl0", ra(0, 24), 64'h0);
      rd_chk("rst_src0", ra(0, 0), 64'h0);
      rd_chk("rst_size0", ra(0, 16), 64'h0);

      round($urandom_range(0, NCHAN - 1), 4'($urandom_range(0, 15)));
      check("final_drained", 64'(exp_q.size()), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
